mont_modexp: RTL
================

MONT_MODEXP -- requirements
Module: mont_modexp

Interface
REQ-001 Parameter WIDTH, default 256, operand/modulus/exponent width in bits; legal values are multiples of 8 from 8 to 1024.
REQ-002 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_start  input  1  start request, sampled every cycle.
REQ-005 i_abort  input  1  synchronous abort of the current operation.
REQ-006 i_a  input  WIDTH  base (cipher text), unsigned.
REQ-007 i_d  input  WIDTH  exponent (key), unsigned.
REQ-008 i_n  input  WIDTH  modulus, unsigned.
REQ-009 o_a_pow_d  output  WIDTH  result a^d mod n.
REQ-010 o_busy  output  1  high while an operation is in progress.
REQ-011 o_finished  output  1  one-cycle pulse when o_a_pow_d becomes valid.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, PREP, MONT, DONE; o_busy SHALL be high in every state except IDLE.
REQ-013 In IDLE, i_start=1 SHALL latch i_a, i_d and i_n into internal registers and enter LOAD; i_start outside IDLE SHALL be ignored.
REQ-014 LOAD (1 cycle) SHALL set t=a, m=1 and the round counter to 0, then enter PREP.
REQ-015 PREP SHALL run exactly WIDTH cycles, each doing t = (2t >= n) ? 2t-n : 2t, so that t = a*2^WIDTH mod n; it then enters MONT.
REQ-016 MONT SHALL run WIDTH rounds i=0..WIDTH-1; each round lasts exactly WIDTH+1 cycles, with two Montgomery multipliers operating in parallel.
REQ-017 Each Montgomery product MM(x,y) SHALL do the following:
- r=0;
- for each bit j of x, LSB first, one bit per cycle: r+=x[j]*y; if r is odd then r+=n; r>>=1;
- a final cycle: if r>=n then r-=n;
- the internal accumulator SHALL be WIDTH+2 bits wide and SHALL never overflow.
REQ-018 At the end of round i: m <= d[i] ? MM(m,t) : m, and t <= MM(t,t), both updated on the same edge.
REQ-019 After round WIDTH-1 the FSM SHALL enter DONE.
- DONE (1 cycle) SHALL load o_a_pow_d with m and pulse o_finished.
- It then returns to IDLE.
REQ-020 Latency from the i_start-accept edge to the o_finished-high cycle SHALL be exactly WIDTH*WIDTH + 2*WIDTH + 2 cycles, independent of data.
REQ-021 o_a_pow_d SHALL hold its value from DONE until the next DONE; it SHALL NOT change during busy.
REQ-022 i_abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge.
- o_finished SHALL not pulse and o_a_pow_d SHALL keep its prior value.
- i_abort has priority over i_start on the same edge; in IDLE it has no effect.
REQ-023 d=0 SHALL yield result 1 mod n.
- a=0 with d≠0 SHALL yield result 0.
REQ-024 Required preconditions are n odd, n≥3 and a<n.
- On violation the result is unspecified.
- The latency of REQ-020 and the handshake SHALL still hold.
REQ-025 i_start asserted in the same cycle as o_finished SHALL be ignored; a new start is accepted from the first IDLE cycle onward.

Reset
REQ-026 i_rst_n=0 SHALL asynchronously force the following, independent of i_clk:
- state IDLE;
- o_busy=0, o_finished=0, o_a_pow_d=0;
- all internal registers to 0.
REQ-027 Reset asserted mid-operation SHALL discard the operation.
- After deassertion the block SHALL be in IDLE and accept i_start on the first clock edge.

Verification
REQ-028 WIDTH=8: a=5, d=7, n=143, pulse i_start -> o_finished exactly 82 cycles later, with o_a_pow_d=47.
REQ-029 WIDTH=8: a=142, d=2, n=143 -> o_a_pow_d=1; a=9, d=0, n=143 -> 1; a=0, d=13, n=143 -> 0.
REQ-030 WIDTH=8: i_start re-pulsed at cycles 10 and 40 of a run (a=5, d=7, n=143), with inputs changed after the start -> a single o_finished at cycle 82 and o_a_pow_d=47.
REQ-031 WIDTH=8: i_abort at cycle 30 -> o_busy low at cycle 31, no o_finished, and o_a_pow_d unchanged; an immediate restart with a=5, d=7, n=143 -> 47 after 82 cycles.
REQ-032 i_rst_n pulsed low mid-MONT (WIDTH=8) -> outputs 0 asynchronously; a later run with a=5, d=7, n=143 -> 47.
REQ-033 WIDTH=256: 1000 random odd n, a<n and random d -> o_a_pow_d matches a software model, and the latency is 66050 cycles every time.

Source files
------------

// File: rtl/mont_modexp.sv
// Modular exponentiation a^d mod n, right-to-left binary method with bit-serial Montgomery products.
// Fixed latency: start-accept edge to o_finished cycle is WIDTH*WIDTH + 2*WIDTH + 2 cycles, data independent.
module mont_modexp #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_a_pow_d,
  output logic             o_busy,
  output logic             o_finished
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PREP,
    S_MONT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, d_q, n_q;
  logic [WIDTH-1:0] t_q, m_q;
  logic [WIDTH-1:0] xm_q, xt_q;
  logic [WIDTH+1:0] r1_q, r2_q;
  logic [CW-1:0]    cnt_q, round_q;
  logic [WIDTH-1:0] res_q;

  logic [WIDTH-1:0] prep_t;
  logic [WIDTH-1:0] m_d, t_d;

  // One Montgomery bit step; the accumulator stays below 2n so WIDTH+2 bits suffice.
  function automatic logic [WIDTH+1:0] mm_step(input logic [WIDTH+1:0] r,
                                               input logic             xb,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] s;
    s = r + (xb ? {2'b00, y} : {(WIDTH+2){1'b0}});
    if (s[0]) s = s + {2'b00, n};
    return s >> 1;
  endfunction

  // Final conditional subtract; the low WIDTH bits of r-n are exact because the result is below n.
  function automatic logic [WIDTH-1:0] mm_fin(input logic [WIDTH+1:0] r,
                                              input logic [WIDTH-1:0] n);
    return (r >= {2'b00, n}) ? (r[WIDTH-1:0] - n) : r[WIDTH-1:0];
  endfunction

  always_comb begin
    prep_t = ({t_q, 1'b0} >= {1'b0, n_q}) ? ({t_q[WIDTH-2:0], 1'b0} - n_q)
                                           : {t_q[WIDTH-2:0], 1'b0};
    m_d    = d_q[0] ? mm_fin(r1_q, n_q) : m_q;
    t_d    = mm_fin(r2_q, n_q);
  end

  always_comb begin
    state_d    = state_q;
    o_busy     = (state_q != S_IDLE);
    o_finished = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_LOAD;
      S_LOAD: state_d = S_PREP;
      S_PREP: if (cnt_q == LAST_BIT) state_d = S_MONT;
      S_MONT: if (cnt_q == LAST_CYC && round_q == LAST_BIT) state_d = S_DONE;
      S_DONE: begin
        o_finished = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      t_q     <= '0;
      m_q     <= '0;
      xm_q    <= '0;
      xt_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      cnt_q   <= '0;
      round_q <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            a_q <= i_a;
            d_q <= i_d;
            n_q <= i_n;
          end
        end
        S_LOAD: begin
          t_q     <= a_q;
          m_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
          cnt_q   <= '0;
          round_q <= '0;
          r1_q    <= '0;
          r2_q    <= '0;
        end
        S_PREP: begin
          t_q <= prep_t;
          if (cnt_q == LAST_BIT) begin
            cnt_q <= '0;
            xm_q  <= m_q;
            xt_q  <= prep_t;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_MONT: begin
          if (cnt_q == LAST_CYC) begin
            // m stays in the normal domain, t in the Montgomery domain.
            m_q     <= m_d;
            t_q     <= t_d;
            xm_q    <= m_d;
            xt_q    <= t_d;
            r1_q    <= '0;
            r2_q    <= '0;
            cnt_q   <= '0;
            round_q <= round_q + 1'b1;
            d_q     <= d_q >> 1;
            if (round_q == LAST_BIT && !i_abort) res_q <= m_d;
          end else begin
            r1_q  <= mm_step(r1_q, xm_q[0], t_q, n_q);
            r2_q  <= mm_step(r2_q, xt_q[0], t_q, n_q);
            xm_q  <= xm_q >> 1;
            xt_q  <= xt_q >> 1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_a_pow_d = res_q;

endmodule
